// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the MeshOfTree configuration sequencer.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_WAIT  = 3'd1,
    ST_LOAD_HOLD  = 3'd2,
    ST_RUN_IDLE   = 3'd3,
    ST_RUN_SETTLE = 3'd4,
    ST_RUN_RESULT = 3'd5
  } state_e;

  // Side slots inside the packed pad vectors {left,bottom,right,top}.
  localparam int SIDE_TOP    = 0;
  localparam int SIDE_RIGHT  = 1;
  localparam int SIDE_BOTTOM = 2;
  localparam int SIDE_LEFT   = 3;

  localparam int CSUM_W = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fabric_cycle_timer.sv
// Loadable down-counter; done is high during the last counted cycle.
module fabric_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign done  = (cnt_q == W'(1));

endmodule

// File: rtl/fabric_cfg_sequencer.sv
// Streams config words into the fabric, then runs vector/result exchanges.
// Optional build macro CFG_CHECKSUM_EN adds a running checksum of accepted words.
module fabric_cfg_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 8,
  parameter int NUM_WORDS     = 34878,
  parameter int HOLD_CYCLES   = 4,
  parameter int PAD_W         = 8,
  parameter int SETTLE_CYCLES = 10,
  localparam int CNT_W        = $clog2(NUM_WORDS + 1),
  localparam int VEC_W        = 4 * PAD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              fab_conf,
  output logic [ADDR_W-1:0] fab_address,
  output logic [DATA_W-1:0] fab_data,
  output logic              fab_clk_en,
  output logic              cfg_done,
  output logic [CNT_W-1:0]  cfg_count,
  output logic [CSUM_W-1:0] cfg_checksum,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [VEC_W-1:0]  vec_in,
  output logic [VEC_W-1:0]  fab_inpads,
  input  logic [VEC_W-1:0]  fab_outpads,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VEC_W-1:0]  res_out
);

  localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] NW       = CNT_W'(NUM_WORDS);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] SETTL_LD = TMR_W'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic              conf_q, conf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              clk_en_q, clk_en_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [VEC_W-1:0]  inpads_q, inpads_d;
  logic [VEC_W-1:0]  res_q, res_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val, tmr_count;
  logic              tmr_done;
  logic              cfg_accept;

  fabric_cycle_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  assign cfg_accept = (state_q == ST_LOAD_WAIT) && cfg_valid;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    clk_en_d = clk_en_q;
    done_d   = done_q;
    count_d  = count_q;
    inpads_d = inpads_q;
    res_d    = res_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;
    // Strobe is registered: timer still at its load value means first hold cycle.
    conf_d   = (state_q == ST_LOAD_HOLD) && (tmr_count == HOLD_LD);
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (cfg_valid) begin
        addr_d   = cfg_addr;
        data_d   = cfg_data;
        if (count_q != NW) count_d = count_q + 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_LOAD_HOLD;
      end
      ST_LOAD_HOLD: if (tmr_done) begin
        if (count_q == NW) begin
          done_d   = 1'b1;
          clk_en_d = 1'b1;
          state_d  = ST_RUN_IDLE;
        end else begin
          state_d  = ST_LOAD_WAIT;
        end
      end
      ST_RUN_IDLE: if (vec_valid) begin
        inpads_d = vec_in;
        tmr_load = 1'b1;
        tmr_val  = SETTL_LD;
        state_d  = ST_RUN_SETTLE;
      end
      ST_RUN_SETTLE: if (tmr_done) begin
        res_d   = fab_outpads;
        state_d = ST_RUN_RESULT;
      end
      ST_RUN_RESULT: if (res_ready) state_d = ST_RUN_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      conf_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      inpads_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      conf_q   <= conf_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      count_q  <= count_d;
      inpads_q <= inpads_d;
      res_q    <= res_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (cfg_accept) csum_d = csum_q + CSUM_W'({cfg_addr, cfg_data});
  end

  always_ff @(posedge clock) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign cfg_checksum = csum_q;
`else
  logic unused_accept;
  assign unused_accept = cfg_accept;
  assign cfg_checksum  = '0;
`endif

  assign cfg_ready   = (state_q == ST_LOAD_WAIT);
  assign vec_ready   = (state_q == ST_RUN_IDLE);
  assign res_valid   = (state_q == ST_RUN_RESULT);
  assign fab_conf    = conf_q;
  assign fab_address = addr_q;
  assign fab_data    = data_q;
  assign fab_clk_en  = clk_en_q;
  assign cfg_done    = done_q;
  assign cfg_count   = count_q;
  assign fab_inpads  = inpads_q;
  assign res_out     = res_q;

endmodule

// File: tb/tb_fabric_cfg_sequencer.sv
// Directed bench for fabric_cfg_sequencer: load timing, vector/result handshake, reset abort.
module tb_fabric_cfg_sequencer;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int NW = 3;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int S  = 10;
  localparam int CW = $clog2(NW + 1);
  localparam int VW = 4 * PW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          fab_conf;
  logic [AW-1:0] fab_address;
  logic [DW-1:0] fab_data;
  logic          fab_clk_en;
  logic          cfg_done;
  logic [CW-1:0] cfg_count;
  logic [31:0]   cfg_checksum;
  logic          vec_valid = 1'b0;
  logic          vec_ready;
  logic [VW-1:0] vec_in = '0;
  logic [VW-1:0] fab_inpads;
  logic [VW-1:0] fab_outpads = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [VW-1:0] res_out;

  fabric_cfg_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .HOLD_CYCLES(H),
    .PAD_W(PW), .SETTLE_CYCLES(S)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .fab_conf(fab_conf), .fab_address(fab_address), .fab_data(fab_data),
    .fab_clk_en(fab_clk_en), .cfg_done(cfg_done), .cfg_count(cfg_count),
    .cfg_checksum(cfg_checksum),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_in(vec_in),
    .fab_inpads(fab_inpads), .fab_outpads(fab_outpads),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int words = 0;
  int t_acc = 0;
  logic [31:0] exp_sum = '0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (fab_conf) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_csum();
`ifdef CFG_CHECKSUM_EN
    return exp_sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    words = 0;
    exp_sum = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready",  cfg_ready,    0);
    chk("rst_conf",   fab_conf,     0);
    chk("rst_addr",   fab_address,  0);
    chk("rst_data",   fab_data,     0);
    chk("rst_clken",  fab_clk_en,   0);
    chk("rst_done",   cfg_done,     0);
    chk("rst_count",  cfg_count,    0);
    chk("rst_csum",   cfg_checksum, 0);
    chk("rst_vready", vec_ready,    0);
    chk("rst_inpads", fab_inpads,   0);
    chk("rst_rvalid", res_valid,    0);
    chk("rst_resout", res_out,      0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One word: optional random idle gaps and junk valids during the hold window.
  task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit junk);
    int n;
    n = 0;
    if (junk) repeat ($urandom_range(0, 2)) begin cfg_valid = 1'b0; tick(); end
    while (!cfg_ready && n < 50) begin tick(); n++; end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    t_acc = cyc;
    words++;
    exp_sum = exp_sum + 32'({a, d});
    cfg_valid = 1'b0;
    chk("acc_addr",  fab_address,  a);
    chk("acc_data",  fab_data,     d);
    chk("acc_count", cfg_count,    words);
    chk("acc_csum",  cfg_checksum, exp_csum());
    for (int i = 1; i <= H; i++) begin
      chk("hold_ready", cfg_ready, 0);
      chk("hold_conf",  fab_conf, (i == 2) ? 1 : 0);
      chk("hold_addr",  fab_address, a);
      chk("hold_data",  fab_data, d);
      if (junk) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_addr = ~a; cfg_data = ~d;
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [VW-1:0] v, input logic [VW-1:0] o, input int hold, input bit b2b);
    int n;
    n = 0;
    while (!vec_ready && n < 50) begin tick(); n++; end
    chk("vec_ready_wait", vec_ready, 1);
    if (b2b) chk("vec_b2b_wait", n, 0);
    vec_valid = 1'b1; vec_in = v; fab_outpads = ~o;
    tick();
    vec_valid = 1'b0;
    chk("vec_inpads", fab_inpads, v);
    chk("vec_busy",   vec_ready,  0);
    for (int i = 1; i <= S; i++) begin
      chk("settle_rvalid", res_valid, 0);
      vec_valid = (i < S);
      vec_in = ~v;
      fab_outpads = (i == S) ? o : ~o;
      tick();
    end
    vec_valid = 1'b0;
    fab_outpads = ~o;
    chk("res_valid_at_s", res_valid,  1);
    chk("res_out",        res_out,    o);
    chk("inpads_kept",    fab_inpads, v);
    repeat (hold) begin
      tick();
      chk("stall_rvalid", res_valid, 1);
      chk("stall_resout", res_out,   o);
      chk("stall_vready", vec_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_rvalid", res_valid, 0);
    chk("hs_vready", vec_ready, 1);
  endtask

  initial begin
    int pc0, t_first;
    do_reset();
    chk_reset_outputs();

    // Valid words before start must be ignored.
    cfg_valid = 1'b1; cfg_addr = 15'h7777; cfg_data = 8'h77;
    tick(); tick();
    cfg_valid = 1'b0;
    chk("idle_count", cfg_count, 0);
    chk("idle_ready", cfg_ready, 0);

    pulse_start();
    chk("start_ready", cfg_ready, 1);
    pc0 = pulse_cnt;
    send_word(15'h0001, 8'h05, 1'b0);
    t_first = t_acc;
    send_word(15'h0002, 8'h0A, 1'b0);
    chk("mid_done", cfg_done, 0);
    send_word(15'h0003, 8'h0C, 1'b0);
    chk("done_cycle", cyc - t_first, NW * (H + 1) - 1);
    chk("load_done",  cfg_done,   1);
    chk("load_clken", fab_clk_en, 1);
    chk("load_count", cfg_count,  NW);
    chk("load_csum",  cfg_checksum, exp_csum());
    chk("load_last_addr", fab_address, 15'h0003);
    chk("conf_pulses", pulse_cnt - pc0, NW);

    pulse_start();
    chk("start_ignored_cfg", cfg_ready, 0);
    chk("start_ignored_vec", vec_ready, 1);

    run_vec(32'h01_02_03_04, 32'hAA55AA55, 5, 1'b0);
    run_vec(32'h5A5AC3C3,    32'h12345678, 0, 1'b1);
    chk("run_done_sticky", cfg_done, 1);

    // Abort a second load after two words.
    do_reset();
    pulse_start();
    send_word(15'h0101, 8'h11, 1'b1);
    send_word(15'h0202, 8'h22, 1'b1);
    do_reset();
    chk_reset_outputs();
    cfg_valid = 1'b1; cfg_addr = 15'h0333; cfg_data = 8'h33;
    tick(); tick();
    cfg_valid = 1'b0;
    chk("abort_nostart_count", cfg_count, 0);

    pulse_start();
    pc0 = pulse_cnt;
    send_word(15'h0404, 8'h44, 1'b1);
    send_word(15'h0505, 8'h55, 1'b1);
    send_word(15'h7FFF, 8'hFF, 1'b1);
    chk("reload_count", cfg_count,   NW);
    chk("reload_done",  cfg_done,    1);
    chk("reload_addr",  fab_address, 15'h7FFF);
    chk("reload_data",  fab_data,    8'hFF);
    chk("reload_csum",  cfg_checksum, exp_csum());
    chk("reload_pulses", pulse_cnt - pc0, NW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
